// File: rtl/alu_pkg.sv
// alu_pkg: FSM state encoding and ALU flag bit positions shared by the divider and the ALU.
package alu_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;
   localparam int OVF   = 0;
   localparam int CARRY = 1;
   localparam int ZERO  = 2;
   localparam int NEG   = 3;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step on {rem, dividend}, compare/subtract done N+1 bits wide.
module div_step #(
   parameter int N = 32
) (
   input  logic [N-1:0] rem_i,
   input  logic [N-1:0] quo_i,
   input  logic [N-1:0] div_i,
   output logic [N-1:0] rem_o,
   output logic [N-1:0] quo_o
);
   logic [N:0] sh;
   logic       ge;
   assign sh    = {rem_i, quo_i[N-1]};
   assign ge    = sh >= {1'b0, div_i};
   assign rem_o = ge ? N'(sh - {1'b0, div_i}) : sh[N-1:0];
   assign quo_o = {quo_i[N-2:0], ge};
endmodule

// File: rtl/seq_divider.sv
// seq_divider: unsigned N-bit sequential restoring divider, one quotient bit per cycle.
module seq_divider
   import alu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] Q,
   output logic [N-1:0] R,
   output logic [3:0]   flags
);
   localparam int CW = $clog2(N + 1);
   div_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
   logic [N-1:0] q_q, q_d, r_q, r_d, rem_s, quo_s;
   logic [3:0] flags_q, flags_d;
   logic accept;
   assign accept = start && (state_q != RUN);
   div_step #(.N(N)) u_step (
      .rem_i(rem_q),
      .quo_i(quo_q),
      .div_i(div_q),
      .rem_o(rem_s),
      .quo_o(quo_s)
   );
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      div_d   = div_q;
      q_d     = q_q;
      r_d     = r_q;
      flags_d = flags_q;
      if (state_q == RUN) begin
         rem_d = rem_s;
         quo_d = quo_s;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            state_d       = DONE;
            q_d           = quo_s;
            r_d           = rem_s;
            flags_d       = '0;
            flags_d[ZERO] = (quo_s == '0);
         end
      end else if (accept && B == '0) begin
         // divide-by-zero skips RUN and reports overflow
         state_d      = DONE;
         q_d          = '1;
         r_d          = A;
         flags_d      = '0;
         flags_d[OVF] = 1'b1;
      end else if (accept) begin
         state_d = RUN;
         quo_d   = A;
         div_d   = B;
         rem_d   = '0;
         cnt_d   = CW'(N);
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         div_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         div_q   <= div_d;
         q_q     <= q_d;
         r_q     <= r_d;
         flags_q <= flags_d;
      end
   end
   assign busy  = (state_q == RUN);
   assign done  = (state_q == DONE);
   assign Q     = q_q;
   assign R     = r_q;
   assign flags = flags_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: random and directed divisions checked against plain / and % arithmetic.
module tb_seq_divider;
   localparam int N = 32;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [N-1:0] A = '0, B = '0, Q, R;
   logic busy, done;
   logic [3:0] flags;
   int vectors = 0, miscompares = 0;
   seq_divider #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
      .busy(busy), .done(done), .Q(Q), .R(R), .flags(flags)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_done(output int lat, output int bc);
      lat = 0;
      bc  = 0;
      while (!done && lat < N + 4) begin
         bc += int'(busy);
         tick();
         lat++;
      end
   endtask
   task automatic check_result(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] eq, er;
      logic [3:0] ef;
      eq = (b == 0) ? '1 : a / b;
      er = (b == 0) ? a : a % b;
      ef = (b == 0) ? 4'b0001 : ((eq == 0) ? 4'b0100 : 4'b0000);
      chk({tag, " done"}, 64'(done), 64'(1));
      chk({tag, " Q"}, 64'(Q), 64'(eq));
      chk({tag, " R"}, 64'(R), 64'(er));
      chk({tag, " flags"}, 64'(flags), 64'(ef));
   endtask
   task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
      int lat, bc;
      logic [N-1:0] hq, hr;
      A = a;
      B = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      A = $urandom;
      B = $urandom;
      wait_done(lat, bc);
      chk({tag, " latency"}, 64'(lat), (b == 0) ? 64'(0) : 64'(N));
      chk({tag, " busy cycles"}, 64'(bc), (b == 0) ? 64'(0) : 64'(N));
      check_result(tag, a, b);
      hq = Q;
      hr = R;
      tick();
      chk({tag, " done pulse"}, 64'(done), 64'(0));
      chk({tag, " hold"}, {Q, R}, {hq, hr});
   endtask
   initial begin
      int lat, bc, t0, gap;
      logic [N-1:0] a, b, hq, hr;
      #12;
      chk("reset busy", 64'(busy), 64'(0));
      chk("reset done", 64'(done), 64'(0));
      chk("reset outs", {Q, R}, 64'(0));
      chk("reset flags", 64'(flags), 64'(0));
      rst = 1'b0;
      tick();
      run_op("100/7", 100, 7);
      run_op("5/0", 5, 0);
      run_op("3/10", 3, 10);
      run_op("max/1", '1, 1);
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 0;
            1: b = N'($urandom_range(1, 15));
            2: b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         run_op("rand", a, b);
      end
      A = 100;
      B = 7;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      A = 9;
      B = 3;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(lat, bc);
      chk("ignore latency", 64'(lat + 5), 64'(N));
      check_result("ignore", 100, 7);
      tick();
      A = 100;
      B = 7;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      #2 rst = 1'b1;
      #1;
      chk("async rst busy", 64'(busy), 64'(0));
      chk("async rst outs", {Q, R}, 64'(0));
      chk("async rst flags", 64'(flags), 64'(0));
      tick();
      rst = 1'b0;
      bc = 0;
      for (int i = 0; i < N + 5; i++) begin
         bc += int'(done) + int'(busy);
         tick();
      end
      chk("aborted no done", 64'(bc), 64'(0));
      run_op("9/3 after rst", 9, 3);
      A = 100;
      B = 7;
      start = 1'b1;
      tick();
      wait_done(lat, bc);
      chk("cont first", 64'(lat), 64'(N));
      check_result("cont", 100, 7);
      hq = Q;
      hr = R;
      for (int k = 0; k < 2; k++) begin
         tick();
         gap = 1;
         bc = 0;
         while (!done && gap < N + 5) begin
            if (Q !== hq || R !== hr) bc++;
            tick();
            gap++;
         end
         chk("cont period", 64'(gap), 64'(N + 1));
         chk("cont stable", 64'(bc), 64'(0));
         check_result("cont", 100, 7);
      end
      start = 1'b0;
      tick();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
